// File: rtl/candy_wb_queue_pkg.sv
// Shared defaults for the candy writeback stage: write-strobe macros and default widths.
// The macros are guarded so other files that define them can coexist with this one.
`ifndef CANDY_DEFINES_V
`define CANDY_DEFINES_V
`define WriteEnable    1'b1
`define WriteDisable   1'b0
`define CANDY_DATA_W     32
`define CANDY_ADDR_W     16
`define CANDY_REG_ADDR_W 5
`endif

package candy_wb_queue_pkg;
  localparam int DATA_W_DEF     = `CANDY_DATA_W;
  localparam int ADDR_W_DEF     = `CANDY_ADDR_W;
  localparam int REG_ADDR_W_DEF = `CANDY_REG_ADDR_W;
  localparam int DEPTH_DEF      = 4;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/candy_wb_fifo.sv
// In-order store queue with youngest-wins address lookup; head visible the cycle after push.
// Pushes are dropped when full and pops are ignored when empty; the caller gates both.
module candy_wb_fifo
  import candy_wb_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  idx;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by cnt are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < cnt) && (addr_mem[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end
endmodule

// File: rtl/candy_wb_queue.sv
// Writeback stage: register writes strobe one cycle after accept; stores queue for the SRAM.
// Register writes never stall; stores stall while the queue is full, with no ready-through-pop.
module candy_wb_queue
  import candy_wb_queue_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_mem,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [REG_ADDR_W-1:0]      in_reg_addr,
  output logic                       reg_write_enable,
  output logic [REG_ADDR_W-1:0]      reg_waddr,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic                       sram_write_enable,
  output logic [ADDR_W-1:0]          sram_waddr,
  output logic [DATA_W-1:0]          sram_wdata,
  input  logic                       sram_ready,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       queue_full,
  output logic                       queue_empty
);
  logic              push;
  logic              pop;
  logic              reg_accept;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign in_ready   = in_is_mem ? !queue_full : 1'b1;
  assign push       = in_valid && in_is_mem && !queue_full;
  assign pop        = !queue_empty && sram_ready;
  assign reg_accept = in_valid && !in_is_mem && (in_reg_addr != '0);

  candy_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (in_addr),
    .push_data   (in_data),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (queue_count),
    .full        (queue_full),
    .empty       (queue_empty)
  );

  // Mask stale storage so the head outputs read zero whenever nothing is pending.
  assign sram_write_enable = !queue_empty;
  assign sram_waddr        = queue_empty ? '0 : head_addr;
  assign sram_wdata        = queue_empty ? '0 : head_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_enable <= `WriteDisable;
      reg_waddr        <= '0;
      reg_wdata        <= '0;
    end else begin
      reg_write_enable <= reg_accept ? `WriteEnable : `WriteDisable;
      if (reg_accept) begin
        reg_waddr <= in_reg_addr;
        reg_wdata <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_candy_wb_queue.sv
// Directed plus randomized checks of candy_wb_queue against a queue-based reference model.
module tb_candy_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_mem;
  logic [31:0] in_data;
  logic [15:0] in_addr;
  logic [4:0]  in_reg_addr;
  logic        reg_write_enable;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        sram_write_enable;
  logic [15:0] sram_waddr;
  logic [31:0] sram_wdata;
  logic        sram_ready;
  logic [15:0] lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [2:0]  queue_count;
  logic        queue_full, queue_empty;

  candy_wb_queue #(.DATA_W(32), .ADDR_W(16), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_mem(in_is_mem), .in_data(in_data), .in_addr(in_addr),
    .in_reg_addr(in_reg_addr), .reg_write_enable(reg_write_enable),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .sram_write_enable(sram_write_enable), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_ready(sram_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .queue_count(queue_count),
    .queue_full(queue_full), .queue_empty(queue_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    ent_t head;
    head = (q.size() != 0) ? q[0] : '0;
    chk("reg_we", reg_write_enable, exp_we);
    chk("reg_waddr", reg_waddr, exp_waddr);
    chk("reg_wdata", reg_wdata, exp_wdata);
    chk("sram_we", sram_write_enable, q.size() != 0);
    chk("sram_waddr", sram_waddr, head.a);
    chk("sram_wdata", sram_wdata, head.d);
    chk("count", queue_count, q.size());
    chk("full", queue_full, q.size() == DEPTH);
    chk("empty", queue_empty, q.size() == 0);
  endtask

  // One clock of stimulus: check combinational outputs before the edge, state after it.
  task automatic cyc(input logic v, input logic m, input logic [31:0] d, input logic [15:0] a,
                     input logic [4:0] ra, input logic sr, input logic [15:0] la);
    logic        exp_rdy, exp_hit;
    logic [31:0] exp_ld;
    in_valid = v; in_is_mem = m; in_data = d; in_addr = a;
    in_reg_addr = ra; sram_ready = sr; lookup_addr = la;
    #3;
    exp_rdy = m ? (q.size() < DEPTH) : 1'b1;
    exp_hit = 1'b0;
    exp_ld  = '0;
    foreach (q[i]) if (q[i].a == la) begin exp_hit = 1'b1; exp_ld = q[i].d; end
    chk("in_ready", in_ready, exp_rdy);
    chk("lookup_hit", lookup_hit, exp_hit);
    chk("lookup_data", lookup_data, exp_ld);
    @(posedge clk);
    #1;
    if (q.size() != 0 && sr) void'(q.pop_front());
    exp_we = 1'b0;
    if (v && exp_rdy) begin
      if (m) q.push_back('{a: a, d: d});
      else if (ra != 0) begin exp_we = 1'b1; exp_waddr = ra; exp_wdata = d; end
    end
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b1; in_is_mem = 1'b1; sram_ready = 1'b1;
    in_addr = 16'h0055; in_data = 32'h1234;
    @(posedge clk);
    #1;
    q.delete();
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    check_state();
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_is_mem = 0; in_data = 0; in_addr = 0;
    in_reg_addr = 0; sram_ready = 0; lookup_addr = 0;
    @(posedge clk);
    do_reset();

    cyc(1, 0, 32'hDEAD, 0, 5'd3, 0, 0);
    chk("dead_strobe", reg_write_enable, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'd5, 0, 5'd0, 0, 0);

    for (int i = 0; i < 4; i++) cyc(1, 1, 32'hA0 + i, 16'h10 + i, 0, 0, 0);
    chk("fill_full", queue_full, 1'b1);
    cyc(1, 1, 32'hBAD, 16'h77, 0, 0, 0);
    cyc(1, 0, 32'h42, 0, 5'd7, 0, 0);
    cyc(1, 1, 32'hBAD, 16'h78, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(1, 1, 32'd1, 16'h20, 0, 0, 16'h20);
    cyc(1, 1, 32'd2, 16'h20, 0, 0, 16'h20);
    cyc(0, 0, 0, 0, 0, 0, 16'h20);
    chk("lookup_newest", lookup_data, 32'd2);
    cyc(0, 0, 0, 0, 0, 0, 16'h21);
    cyc(1, 1, 32'd7, 16'h22, 0, 0, 16'h22);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 16'h22);

    for (int i = 0; i < DEPTH - 1; i++) cyc(1, 1, $urandom, 16'h40 + i, 0, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1, 1, $urandom, 16'h43 + i, 0, 1, 16'h40 + i);
      chk("steady_count", queue_count, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
          16'h30 + 16'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
          $urandom_range(0, 2) == 0, 16'h30 + 16'($urandom_range(0, 3)));

    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hC0 + i, 16'h60 + i, 0, 0, 0);
    cyc(1, 0, 32'h99, 0, 5'd9, 0, 0);
    do_reset();
    chk("post_rst_we", sram_write_enable, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 16'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
